// File: rtl/enc_pkg.sv
// Shared types and constants for the 8-to-3 bitmap encoder.
// Index width and bitmap width are tied: ENC_N == 2**ENC_W.
package enc_pkg;
    localparam int ENC_W = 3;
    localparam int ENC_N = 8;

    typedef enum logic {
        IDLE,
        EMIT
    } state_t;

    typedef logic [ENC_W-1:0] idx_t;
endpackage

// File: rtl/bitmap_encoder8to3_if.sv
// Bitmap-in / index-out handshake bundle.
// The slave modport is the encoder; the master modport is the environment.
interface bitmap_encoder8to3_if #(
    parameter int W = enc_pkg::ENC_W,
    parameter int N = enc_pkg::ENC_N
);
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] in_bits;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_idx;
    logic         out_last;
    logic         out_empty;

    modport master (
        output in_valid, in_bits, out_ready,
        input  in_ready, out_valid, out_idx, out_last, out_empty
    );

    modport slave (
        input  in_valid, in_bits, out_ready,
        output in_ready, out_valid, out_idx, out_last, out_empty
    );
endinterface

// File: rtl/lsb_prio_enc8to3.sv
// Combinational lowest-set-bit encoder with single-bit detect.
// one_hot is true when exactly one bit of mask is set.
module lsb_prio_enc8to3
    import enc_pkg::*;
(
    input  logic [ENC_N-1:0] mask,
    output idx_t             idx,
    output logic             any,
    output logic             one_hot
);
    always_comb begin
        idx = '0;
        // Descending scan so the lowest set bit is the last to win.
        for (int i = ENC_N - 1; i >= 0; i--) begin
            if (mask[i]) idx = idx_t'(i);
        end
    end

    assign any     = |mask;
    assign one_hot = any && ((mask & (mask - ENC_N'(1))) == '0);
endmodule

// File: rtl/bitmap_encoder8to3.sv
// Sequential bitmap-to-index encoder: one index per beat, lowest first.
// A new bitmap may be taken on the final beat, so streams have no bubbles.
module bitmap_encoder8to3
    import enc_pkg::*;
#(
    parameter int W = ENC_W,
    parameter int N = ENC_N
) (
    input logic                 clk,
    input logic                 rst_n,
    bitmap_encoder8to3_if.slave bus
);
    state_t       state;
    logic [N-1:0] mask;
    logic         zero_flag;
    logic [W-1:0] enc_idx;
    logic         any;
    logic         one_hot;
    logic         emit;
    logic         fire;
    logic         accept;

    lsb_prio_enc8to3 u_enc (
        .mask    (mask),
        .idx     (enc_idx),
        .any     (any),
        .one_hot (one_hot)
    );

    assign emit          = (state == EMIT);
    assign bus.out_valid = emit;
    assign bus.out_idx   = (emit && any) ? enc_idx : '0;
    assign bus.out_last  = emit && (one_hot || zero_flag);
    assign bus.out_empty = emit && zero_flag;

    assign fire         = bus.out_valid && bus.out_ready;
    assign bus.in_ready = rst_n && (!emit || (fire && bus.out_last));
    assign accept       = bus.in_valid && bus.in_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            mask      <= '0;
            zero_flag <= 1'b0;
        end else if (accept) begin
            state     <= EMIT;
            mask      <= bus.in_bits;
            zero_flag <= ~|bus.in_bits;
        end else if (fire) begin
            mask <= mask & ~(N'(1) << enc_idx);
            if (bus.out_last) begin
                state     <= IDLE;
                zero_flag <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_bitmap_encoder8to3.sv
// Scoreboard bench for bitmap_encoder8to3: a model queues expected beats,
// a negedge monitor pops them on every output handshake.
module tb_bitmap_encoder8to3;
    import enc_pkg::*;

    typedef struct packed {
        logic [2:0] idx;
        logic       last;
        logic       empty;
    } beat_t;

    logic  clk = 1'b0;
    logic  rst_n;
    int    errors = 0;
    int    checks = 0;
    int    hs = 0;
    int    cyc = 0;
    beat_t q[$];
    beat_t got;
    beat_t exp_b;
    beat_t held;
    logic  stall_p = 1'b0;

    bitmap_encoder8to3_if bus ();

    bitmap_encoder8to3 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        got = {bus.out_idx, bus.out_last, bus.out_empty};
        if (rst_n === 1'b1 && bus.out_valid === 1'b1) begin
            if (stall_p) begin
                checks++;
                if (got !== held) begin
                    errors++;
                    $display("FAIL stall_hold: got %b required %b", got, held);
                end
            end
            if (bus.out_ready === 1'b1) begin
                hs++;
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_beat: got %b required none", got);
                end else begin
                    exp_b = q.pop_front();
                    if (got !== exp_b) begin
                        errors++;
                        $display("FAIL beat: got idx=%0d last=%b empty=%b required idx=%0d last=%b empty=%b",
                                 got.idx, got.last, got.empty,
                                 exp_b.idx, exp_b.last, exp_b.empty);
                    end
                end
            end
        end
        stall_p = (rst_n === 1'b1) && (bus.out_valid === 1'b1) && (bus.out_ready === 1'b0);
        held    = got;
    end

    task automatic push_model(input logic [7:0] b);
        int hi;
        hi = -1;
        if (b == 8'h00) begin
            q.push_back({3'd0, 1'b1, 1'b1});
        end else begin
            for (int i = 0; i < 8; i++) if (b[i]) hi = i;
            for (int i = 0; i < 8; i++) begin
                if (b[i]) q.push_back({3'(i), (i == hi), 1'b0});
            end
        end
    endtask

    // Call just after a posedge; returns just after the accepting edge.
    task automatic send(input logic [7:0] b);
        logic ok;
        ok = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_bits  = b;
        for (int n = 0; n < 50 && !ok; n++) begin
            @(negedge clk);
            if (bus.in_ready === 1'b1) ok = 1'b1;
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL accept_timeout: got in_ready=0 required 1 for %h", b);
        end
        push_model(b);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_bits  = 8'h5A;
    endtask

    task automatic wait_drain(input string name);
        for (int n = 0; n < 100 && q.size() != 0; n++) @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: got %0d pending required 0", name, q.size());
        end
        q.delete();
    endtask

    task automatic test_reset();
        rst_n         = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_bits   = 8'hFF;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks += 5;
        if (bus.out_valid !== 1'b0) begin
            errors++; $display("FAIL rst_out_valid: got %b required 0", bus.out_valid);
        end
        if (bus.out_idx !== 3'd0) begin
            errors++; $display("FAIL rst_out_idx: got %0d required 0", bus.out_idx);
        end
        if (bus.out_last !== 1'b0) begin
            errors++; $display("FAIL rst_out_last: got %b required 0", bus.out_last);
        end
        if (bus.out_empty !== 1'b0) begin
            errors++; $display("FAIL rst_out_empty: got %b required 0", bus.out_empty);
        end
        if (bus.in_ready !== 1'b0) begin
            errors++; $display("FAIL rst_in_ready: got %b required 0", bus.in_ready);
        end
        @(posedge clk);
        #1;
        rst_n        = 1'b1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        checks += 2;
        if (bus.in_ready !== 1'b1) begin
            errors++; $display("FAIL post_rst_in_ready: got %b required 1", bus.in_ready);
        end
        if (bus.out_valid !== 1'b0) begin
            errors++; $display("FAIL post_rst_out_valid: got %b required 0", bus.out_valid);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_sparse();
        bus.out_ready = 1'b1;
        send(8'b1010_0100);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks += 2;
            if (bus.out_valid !== 1'b1) begin
                errors++; $display("FAIL sparse_valid%0d: got %b required 1", i, bus.out_valid);
            end
            if (bus.in_ready !== (i == 2)) begin
                errors++; $display("FAIL sparse_in_ready%0d: got %b required %b", i, bus.in_ready, (i == 2));
            end
        end
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++; $display("FAIL sparse_idle: got %b required 0", bus.out_valid);
        end
        wait_drain("sparse");
        @(posedge clk);
        #1;
    endtask

    task automatic test_zero();
        bus.out_ready = 1'b1;
        send(8'h00);
        @(negedge clk);
        checks++;
        if ({bus.out_valid, bus.out_empty, bus.out_last} !== 3'b111) begin
            errors++;
            $display("FAIL zero_beat: got v/e/l=%b required 111",
                     {bus.out_valid, bus.out_empty, bus.out_last});
        end
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++; $display("FAIL zero_idle: got %b required 0", bus.out_valid);
        end
        wait_drain("zero");
        @(posedge clk);
        #1;
    endtask

    task automatic test_stall();
        int hs0;
        hs0 = hs;
        bus.out_ready = 1'b1;
        send(8'hFF);
        for (int c = 0; c < 60 && q.size() != 0; c++) begin
            bus.out_ready = (c % 3 == 0);
            @(posedge clk);
            #1;
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        checks += 2;
        if (hs - hs0 != 8) begin
            errors++; $display("FAIL stall_handshakes: got %0d required 8", hs - hs0);
        end
        if (bus.out_valid !== 1'b0) begin
            errors++; $display("FAIL stall_idle: got %b required 0", bus.out_valid);
        end
        wait_drain("stall");
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back();
        int a1;
        int a2;
        a1 = -1;
        a2 = -1;
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_bits   = 8'h81;
        for (int n = 0; n < 30 && a2 < 0; n++) begin
            @(negedge clk);
            if (bus.in_ready === 1'b1) begin
                if (a1 < 0) begin
                    a1 = cyc;
                    push_model(8'h81);
                    @(posedge clk);
                    #1;
                    bus.in_bits = 8'h10;
                end else begin
                    a2 = cyc;
                    push_model(8'h10);
                    checks++;
                    if (!(bus.out_valid === 1'b1 && bus.out_idx === 3'd7 && bus.out_last === 1'b1)) begin
                        errors++;
                        $display("FAIL b2b_accept_beat: got v=%b idx=%0d last=%b required v=1 idx=7 last=1",
                                 bus.out_valid, bus.out_idx, bus.out_last);
                    end
                    @(posedge clk);
                    #1;
                    bus.in_valid = 1'b0;
                end
            end
        end
        checks++;
        if (a1 < 0 || a2 - a1 != 2) begin
            errors++; $display("FAIL b2b_gap: got %0d cycles required 2", a2 - a1);
        end
        @(negedge clk);
        checks++;
        if (!(bus.out_valid === 1'b1 && bus.out_idx === 3'd4 && bus.out_last === 1'b1)) begin
            errors++;
            $display("FAIL b2b_second: got v=%b idx=%0d last=%b required v=1 idx=4 last=1",
                     bus.out_valid, bus.out_idx, bus.out_last);
        end
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++; $display("FAIL b2b_idle: got %b required 0", bus.out_valid);
        end
        wait_drain("b2b");
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid();
        bus.out_ready = 1'b1;
        send(8'h0F);
        @(negedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if (!(bus.out_valid === 1'b1 && bus.out_idx === 3'd1)) begin
            errors++;
            $display("FAIL mid_second_beat: got v=%b idx=%0d required v=1 idx=1",
                     bus.out_valid, bus.out_idx);
        end
        @(posedge clk);
        #1;
        q.delete();
        @(negedge clk);
        checks++;
        if ({bus.out_valid, bus.out_idx, bus.out_last, bus.out_empty, bus.in_ready} !== 7'b0) begin
            errors++;
            $display("FAIL mid_rst_outputs: got %b required 0000000",
                     {bus.out_valid, bus.out_idx, bus.out_last, bus.out_empty, bus.in_ready});
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++; $display("FAIL mid_release_ready: got %b required 1", bus.in_ready);
        end
        @(posedge clk);
        #1;
        send(8'h08);
        @(negedge clk);
        checks++;
        if (!(bus.out_valid === 1'b1 && bus.out_idx === 3'd3 && bus.out_last === 1'b1)) begin
            errors++;
            $display("FAIL mid_new_beat: got v=%b idx=%0d last=%b required v=1 idx=3 last=1",
                     bus.out_valid, bus.out_idx, bus.out_last);
        end
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++; $display("FAIL mid_idle: got %b required 0", bus.out_valid);
        end
        wait_drain("mid");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_bits   = 8'h00;
        bus.out_ready = 1'b0;
        test_reset();
        test_sparse();
        test_zero();
        test_stall();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
